// File: rtl/bus_demux_3ch_if.sv
// Bus-side signal bundle for the 3-channel demultiplexer.
// The master side is the bus source plus the three consumers; the slave side is the demux.
interface bus_demux_3ch_if #(
  parameter int unsigned word_size = 16,
  parameter int unsigned sel_size  = 2
);

  logic [word_size-1:0] data_in;
  logic [sel_size-1:0]  sel;
  logic                 in_valid;
  logic                 in_ready;

  logic [word_size-1:0] data_a;
  logic [word_size-1:0] data_b;
  logic [word_size-1:0] data_c;
  logic                 valid_a;
  logic                 valid_b;
  logic                 valid_c;
  logic                 ack_a;
  logic                 ack_b;
  logic                 ack_c;

  logic                 sel_err;

  modport master (
    output data_in, sel, in_valid, ack_a, ack_b, ack_c,
    input  in_ready, data_a, data_b, data_c, valid_a, valid_b, valid_c, sel_err
  );

  modport slave (
    input  data_in, sel, in_valid, ack_a, ack_b, ack_c,
    output in_ready, data_a, data_b, data_c, valid_a, valid_b, valid_c, sel_err
  );

endinterface

// File: rtl/bus_demux_3ch.sv
// Registered 1-to-3 bus demultiplexer. Each destination owns a one-entry holding
// register with valid/ack, so a stalled consumer back-pressures the bus source.
// Channel index: 0 = a (ALU operand), 1 = b (memory write-data), 2 = c (bus_1 side).
module bus_demux_3ch #(
  parameter int unsigned word_size = 16,
  parameter int unsigned sel_size  = 2
) (
  input  logic             clk,
  input  logic             rst,
  bus_demux_3ch_if.slave   bus
);

  localparam int unsigned num_ch = 3;

  logic [word_size-1:0] data_q [num_ch];
  logic [word_size-1:0] data_d [num_ch];
  logic [num_ch-1:0]    valid_q;
  logic [num_ch-1:0]    valid_d;
  logic                 sel_err_q;
  logic                 sel_err_d;

  logic [num_ch-1:0]    sel_hit;
  logic [num_ch-1:0]    ack_vec;
  logic [num_ch-1:0]    load;
  logic                 in_ready_c;

  // Decode destination, derive ready (independent of in_valid) and next state
  always_comb begin
    sel_hit    = '0;
    ack_vec    = {bus.ack_c, bus.ack_b, bus.ack_a};
    in_ready_c = 1'b0;
    load       = '0;
    valid_d    = valid_q;
    sel_err_d  = sel_err_q;
    for (int unsigned i = 0; i < num_ch; i++) begin
      data_d[i] = data_q[i];
    end

    case (bus.sel)
      sel_size'(0): sel_hit = 3'b001;
      sel_size'(1): sel_hit = 3'b010;
      sel_size'(2): sel_hit = 3'b100;
      default:      sel_hit = 3'b000;
    endcase

    // A slot is free when empty or being drained this same cycle
    in_ready_c = rst & (|(sel_hit & (~valid_q | ack_vec)));

    if (bus.in_valid && in_ready_c) begin
      load = sel_hit;
    end

    // Load wins over consume, keeping valid high for full per-channel throughput
    valid_d = load | (valid_q & ~ack_vec);

    for (int unsigned i = 0; i < num_ch; i++) begin
      if (load[i]) begin
        data_d[i] = bus.data_in;
      end
    end

    if (bus.in_valid && (sel_hit == '0)) begin
      sel_err_d = 1'b1;
    end
  end

  // Holding registers and sticky error flag; reset discards all held words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      sel_err_q <= 1'b0;
      for (int unsigned i = 0; i < num_ch; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
      for (int unsigned i = 0; i < num_ch; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.data_a   = data_q[0];
  assign bus.data_b   = data_q[1];
  assign bus.data_c   = data_q[2];
  assign bus.valid_a  = valid_q[0];
  assign bus.valid_b  = valid_q[1];
  assign bus.valid_c  = valid_q[2];
  assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_bus_demux_3ch.sv
// Directed bench for bus_demux_3ch: reset, single transfer, back-pressure,
// streaming, illegal select and reset during operation.
module tb_bus_demux_3ch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bus_demux_3ch_if #(.word_size(16), .sel_size(2)) bus ();

  bus_demux_3ch #(.word_size(16), .sel_size(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in  = '0;
    bus.sel      = 2'd0;
    bus.in_valid = 1'b0;
    bus.ack_a    = 1'b0;
    bus.ack_b    = 1'b0;
    bus.ack_c    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.valid_a, bus.valid_b, bus.valid_c} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid got=%b want=000", {bus.valid_a, bus.valid_b, bus.valid_c});
    end
    n_checks++;
    if ({bus.data_a, bus.data_b, bus.data_c} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data got=%h want=0", {bus.data_a, bus.data_b, bus.data_c});
    end
    n_checks++;
    if (bus.sel_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_sel_err got=%b want=0", bus.sel_err);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b1;
    bus.sel = 2'd0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_single_transfer();
    tick();
    bus.data_in  = 16'h1234;
    bus.sel      = 2'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.data_b !== 16'h1234 || bus.valid_b !== 1'b1) begin
      n_fail++; $display("FAIL single_load got data_b=%h valid_b=%b want 1234/1", bus.data_b, bus.valid_b);
    end
    n_checks++;
    if (bus.valid_a !== 1'b0 || bus.valid_c !== 1'b0) begin
      n_fail++; $display("FAIL single_others got valid_a=%b valid_c=%b want 0/0", bus.valid_a, bus.valid_c);
    end
    bus.ack_b = 1'b1;
    tick();
    n_checks++;
    if (bus.valid_b !== 1'b0 || bus.data_b !== 16'h1234) begin
      n_fail++; $display("FAIL single_consume got data_b=%h valid_b=%b want 1234/0", bus.data_b, bus.valid_b);
    end
    // ack with nothing held must leave the channel alone
    tick();
    bus.ack_b = 1'b0;
    n_checks++;
    if (bus.valid_b !== 1'b0 || bus.data_b !== 16'h1234) begin
      n_fail++; $display("FAIL idle_ack got data_b=%h valid_b=%b want 1234/0", bus.data_b, bus.valid_b);
    end
  endtask

  task automatic test_back_pressure();
    bus.data_in  = 16'hAAAA;
    bus.sel      = 2'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.data_in = 16'hBBBB;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", i, bus.in_ready);
      end
      n_checks++;
      if (bus.data_a !== 16'hAAAA || bus.valid_a !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d got data_a=%h valid_a=%b want AAAA/1", i, bus.data_a, bus.valid_a);
      end
      tick();
    end
    bus.ack_a = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
    end
    tick();
    bus.ack_a    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.data_a !== 16'hBBBB || bus.valid_a !== 1'b1) begin
      n_fail++; $display("FAIL bp_reload got data_a=%h valid_a=%b want BBBB/1", bus.data_a, bus.valid_a);
    end
    bus.ack_a = 1'b1;
    tick();
    bus.ack_a = 1'b0;
  endtask

  task automatic test_streaming();
    bus.ack_c    = 1'b1;
    bus.sel      = 2'd2;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.data_in = 16'(i);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready word=%0d got=%b want=1", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.data_c !== 16'(i) || bus.valid_c !== 1'b1) begin
        n_fail++; $display("FAIL stream_data word=%0d got data_c=%h valid_c=%b want %h/1", i, bus.data_c, bus.valid_c, 16'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    bus.ack_c = 1'b0;
    n_checks++;
    if (bus.valid_c !== 1'b0 || bus.data_c !== 16'h0004) begin
      n_fail++; $display("FAIL stream_drain got data_c=%h valid_c=%b want 0004/0", bus.data_c, bus.valid_c);
    end
  endtask

  task automatic test_illegal_select();
    logic [15:0] words [3];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    bus.data_in  = 16'hDEAD;
    bus.sel      = 2'd3;
    bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.sel_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pre got in_ready=%b sel_err=%b want 0/0", bus.in_ready, bus.sel_err);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.sel_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_flag got=%b want=1", bus.sel_err);
    end
    n_checks++;
    if ({bus.valid_a, bus.valid_b, bus.valid_c} !== 3'b000 ||
        bus.data_a !== 16'hBBBB || bus.data_b !== 16'h1234 || bus.data_c !== 16'h0004) begin
      n_fail++; $display("FAIL illegal_untouched got a=%h b=%h c=%h v=%b want BBBB/1234/0004/000",
                         bus.data_a, bus.data_b, bus.data_c, {bus.valid_a, bus.valid_b, bus.valid_c});
    end
    // Ten legal transfers round-robin with all consumers draining
    bus.ack_a = 1'b1;
    bus.ack_b = 1'b1;
    bus.ack_c = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.sel     = 2'(i % 3);
      bus.data_in = words[i % 3] + 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.data_a !== 16'h111A || bus.data_b !== 16'h2229 || bus.data_c !== 16'h333B) begin
      n_fail++; $display("FAIL illegal_legal_after got a=%h b=%h c=%h want 111A/2229/333B", bus.data_a, bus.data_b, bus.data_c);
    end
    n_checks++;
    if (bus.sel_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky got=%b want=1", bus.sel_err);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sel     = 2'(i);
      bus.data_in = 16'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.valid_a, bus.valid_b, bus.valid_c} !== 3'b111 ||
        bus.data_a !== 16'h0001 || bus.data_b !== 16'h0002 || bus.data_c !== 16'h0003) begin
      n_fail++; $display("FAIL mid_fill got a=%h b=%h c=%h v=%b want 0001/0002/0003/111",
                         bus.data_a, bus.data_b, bus.data_c, {bus.valid_a, bus.valid_b, bus.valid_c});
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.valid_a, bus.valid_b, bus.valid_c} !== 3'b000 ||
        {bus.data_a, bus.data_b, bus.data_c} !== 48'h0 || bus.sel_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got a=%h b=%h c=%h v=%b err=%b want all 0",
                         bus.data_a, bus.data_b, bus.data_c, {bus.valid_a, bus.valid_b, bus.valid_c}, bus.sel_err);
    end
    tick();
    #2 rst = 1'b1;
    tick();
    bus.sel      = 2'd0;
    bus.data_in  = 16'h00FF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.data_a !== 16'h00FF || {bus.valid_a, bus.valid_b, bus.valid_c} !== 3'b100) begin
      n_fail++; $display("FAIL mid_after got data_a=%h v=%b want 00FF/100", bus.data_a, {bus.valid_a, bus.valid_b, bus.valid_c});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_transfer();
    test_back_pressure();
    test_streaming();
    test_illegal_select();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
